ad7621_line_sequencer: RTL and testbench

Line-scan sequencer that drives the AD7621 capture block for one linear-sensor line per trigger. On each accepted trigger it issues the capture restart pulse, holds the sensor start pulse for a programmable settle window, then emits a programmable number of single-cycle conversion-start strobes at a fixed pixel period. It sits between the frame/trigger logic and the AD7621 capture block, and reports line completion, a wrapping line count and trigger overruns.

---
 rtl/ad7621_line_sequencer.sv | 145 ++++++++++++++
 tb/tb_ad7621_line_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7621_line_sequencer.sv
// ad7621_line_sequencer: one linear-sensor line per accepted trigger.
// restart pulse -> settle window -> PIX_TOTAL conversion strobes -> done.
module ad7621_line_sequencer #(
  parameter int PIX_TOTAL  = 2088,
  parameter int PERIOD_MIN = 40
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  input  logic        trig,
  input  logic [15:0] cfg_settle,
  input  logic [15:0] cfg_period,
  output logic        ad7621_restart,
  output logic        ad7621_start,
  output logic        sensor_st,
  output logic        busy,
  output logic        line_done,
  output logic [15:0] line_cnt,
  output logic        trig_overrun
);

  localparam int SW = $clog2(PIX_TOTAL + 1);
  localparam logic [SW-1:0] PIX_L = SW'(PIX_TOTAL);
  localparam logic [15:0]   PMIN  = 16'(PERIOD_MIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESTART,
    S_SETTLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [15:0]   r_s;
  logic [15:0]   r_p;
  logic [15:0]   r_cnt;
  logic [15:0]   w_cnt_nx;
  logic [SW-1:0] r_str;
  logic [SW-1:0] w_str_nx;
  logic [15:0]   w_s;
  logic [15:0]   w_p;
  logic          w_accept;
  logic          w_restart;
  logic          w_start;
  logic          w_sst;
  logic          w_done;
  logic          w_ovr;

  assign w_s      = (cfg_settle == 16'd0) ? 16'd1 : cfg_settle;
  assign w_p      = (cfg_period < PMIN) ? PMIN : cfg_period;
  assign w_accept = (r_state == S_IDLE) && trig && enable;
  assign w_ovr    = trig && ((r_state != S_IDLE) || !enable);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_str_nx   = r_str;
    w_restart  = 1'b0;
    w_start    = 1'b0;
    w_sst      = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nx = S_RESTART;
      end
      S_RESTART: begin
        w_restart  = 1'b1;
        w_cnt_nx   = 16'd0;
        w_state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        w_sst = 1'b1;
        if (r_cnt == r_s - 16'd1) begin
          w_cnt_nx   = 16'd0;
          w_str_nx   = '0;
          w_state_nx = S_SCAN;
        end else begin
          w_cnt_nx = r_cnt + 16'd1;
        end
      end
      S_SCAN: begin
        if (r_cnt == 16'd0 && r_str != PIX_L) begin
          w_start  = 1'b1;
          w_str_nx = r_str + SW'(1);
        end
        // the trailing period after the last strobe ends the line
        if (r_cnt == r_p - 16'd1) begin
          w_cnt_nx = 16'd0;
          if (r_str == PIX_L) w_state_nx = S_DONE;
        end else begin
          w_cnt_nx = r_cnt + 16'd1;
        end
      end
      S_DONE: begin
        w_done     = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (r_state != S_IDLE && !enable) begin
      w_state_nx = S_IDLE;
      w_restart  = 1'b1;
      w_start    = 1'b0;
      w_sst      = 1'b0;
      w_done     = 1'b0;
      w_cnt_nx   = 16'd0;
      w_str_nx   = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state        <= S_IDLE;
      r_s            <= 16'd0;
      r_p            <= 16'd0;
      r_cnt          <= 16'd0;
      r_str          <= '0;
      ad7621_restart <= 1'b0;
      ad7621_start   <= 1'b0;
      sensor_st      <= 1'b0;
      busy           <= 1'b0;
      line_done      <= 1'b0;
      line_cnt       <= 16'd0;
      trig_overrun   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_str   <= w_str_nx;
      if (w_accept) begin
        r_s <= w_s;
        r_p <= w_p;
      end
      ad7621_restart <= w_restart;
      ad7621_start   <= w_start;
      sensor_st      <= w_sst;
      busy           <= w_accept || (r_state != S_IDLE);
      line_done      <= w_done;
      line_cnt       <= line_cnt + 16'(w_done);
      trig_overrun   <= w_ovr;
    end
  end

endmodule

// File: tb/tb_ad7621_line_sequencer.sv
// Directed bench for ad7621_line_sequencer with PIX_TOTAL=8.
// Events are logged by edge number and compared against hand timings.
module tb_ad7621_line_sequencer;

  localparam int PIX = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] cfg_settle = 16'd5;
  logic [15:0] cfg_period = 16'd40;
  logic        ad7621_restart;
  logic        ad7621_start;
  logic        sensor_st;
  logic        busy;
  logic        line_done;
  logic [15:0] line_cnt;
  logic        trig_overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic busy_d = 1'b0;
  int q_rst[$];
  int q_st[$];
  int q_sst[$];
  int q_done[$];
  int q_ovr[$];
  int q_bfall[$];

  ad7621_line_sequencer #(
    .PIX_TOTAL (PIX),
    .PERIOD_MIN(40)
  ) dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .enable        (enable),
    .trig          (trig),
    .cfg_settle    (cfg_settle),
    .cfg_period    (cfg_period),
    .ad7621_restart(ad7621_restart),
    .ad7621_start  (ad7621_start),
    .sensor_st     (sensor_st),
    .busy          (busy),
    .line_done     (line_done),
    .line_cnt      (line_cnt),
    .trig_overrun  (trig_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ad7621_restart) q_rst.push_back(cyc);
    if (ad7621_start) q_st.push_back(cyc);
    if (sensor_st) q_sst.push_back(cyc);
    if (line_done) q_done.push_back(cyc);
    if (trig_overrun) q_ovr.push_back(cyc);
    if (!busy && busy_d) q_bfall.push_back(cyc);
    busy_d <= busy;
  end

  task automatic pulse_trig(output int t);
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    t = cyc;
  endtask

  task automatic trig_at(input int e);
    while (cyc < e - 1) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ad7621_restart, ad7621_start, sensor_st, busy,
         line_done, trig_overrun} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=000000",
               {ad7621_restart, ad7621_start, sensor_st, busy,
                line_done, trig_overrun});
    end
    checks++;
    if (line_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL reset_line_cnt got=%h exp=0000", line_cnt);
    end
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int t0;
    int br = q_rst.size();
    int bs = q_st.size();
    int bss = q_sst.size();
    int bd = q_done.size();
    int bf = q_bfall.size();
    logic [15:0] lc = line_cnt;
    int n;
    cfg_settle = 16'd5;
    cfg_period = 16'd40;
    pulse_trig(t0);
    cfg_settle = 16'd9;
    cfg_period = 16'd100;
    wait_until(t0 + 340);
    checks++;
    if (q_rst.size() - br != 1 || q_rst[br] != t0 + 1) begin
      failures++;
      $display("FAIL basic_restart n=%0d at=+%0d exp n=1 at=+1",
               q_rst.size() - br, q_rst[br] - t0);
    end
    n = q_sst.size() - bss;
    checks++;
    if (n != 5 || q_sst[bss] != t0 + 2 || q_sst[bss+n-1] != t0 + 6) begin
      failures++;
      $display("FAIL basic_sensor_st n=%0d exp n=5 cycles 2..6", n);
    end
    n = q_st.size() - bs;
    checks++;
    if (n != PIX) begin
      failures++;
      $display("FAIL basic_start_count got=%0d exp=%0d", n, PIX);
    end
    for (int k = 0; k < n && k < PIX; k++) begin
      checks++;
      if (q_st[bs+k] != t0 + 7 + 40 * k) begin
        failures++;
        $display("FAIL basic_start%0d got=+%0d exp=+%0d",
                 k, q_st[bs+k] - t0, 7 + 40 * k);
      end
    end
    checks++;
    if (q_done.size() - bd != 1 || q_done[bd] != t0 + 327) begin
      failures++;
      $display("FAIL basic_line_done n=%0d at=+%0d exp n=1 at=+327",
               q_done.size() - bd, q_done[bd] - t0);
    end
    checks++;
    if (q_bfall.size() - bf != 1 || q_bfall[bf] != t0 + 328) begin
      failures++;
      $display("FAIL basic_busy_fall at=+%0d exp=+328", q_bfall[bf] - t0);
    end
    checks++;
    if (line_cnt !== lc + 16'd1) begin
      failures++;
      $display("FAIL basic_line_cnt got=%h exp=%h", line_cnt, lc + 16'd1);
    end
  endtask

  task automatic test_clamp();
    int t0;
    int bs = q_st.size();
    int bss = q_sst.size();
    int bd = q_done.size();
    int n;
    cfg_settle = 16'd0;
    cfg_period = 16'd3;
    pulse_trig(t0);
    wait_until(t0 + 330);
    n = q_sst.size() - bss;
    checks++;
    if (n != 1 || q_sst[bss] != t0 + 2) begin
      failures++;
      $display("FAIL clamp_settle n=%0d exp n=1 at=+2", n);
    end
    n = q_st.size() - bs;
    checks++;
    if (n != PIX) begin
      failures++;
      $display("FAIL clamp_start_count got=%0d exp=%0d", n, PIX);
    end
    for (int k = 0; k < n && k < PIX; k++) begin
      checks++;
      if (q_st[bs+k] != t0 + 3 + 40 * k) begin
        failures++;
        $display("FAIL clamp_start%0d got=+%0d exp=+%0d",
                 k, q_st[bs+k] - t0, 3 + 40 * k);
      end
    end
    checks++;
    if (q_done.size() - bd != 1 || q_done[bd] != t0 + 323) begin
      failures++;
      $display("FAIL clamp_line_done at=+%0d exp=+323", q_done[bd] - t0);
    end
    cfg_settle = 16'd5;
    cfg_period = 16'd40;
  endtask

  task automatic test_overrun();
    int t0;
    int t1;
    int br = q_rst.size();
    int bs = q_st.size();
    int bd = q_done.size();
    int bo = q_ovr.size();
    logic [15:0] lc = line_cnt;
    pulse_trig(t0);
    trig_at(t0 + 100);
    trig_at(t0 + 327);
    wait_until(t0 + 335);
    enable = 1'b0;
    pulse_trig(t1);
    wait_until(t1 + 3);
    enable = 1'b1;
    checks++;
    if (q_ovr.size() - bo != 3 || q_ovr[bo] != t0 + 100 ||
        q_ovr[bo+1] != t0 + 327 || q_ovr[bo+2] != t1) begin
      failures++;
      $display("FAIL overrun_pulses n=%0d exp n=3 at +100,+327,idle",
               q_ovr.size() - bo);
    end
    checks++;
    if (q_st.size() - bs != PIX) begin
      failures++;
      $display("FAIL overrun_starts got=%0d exp=%0d", q_st.size() - bs, PIX);
    end
    checks++;
    if (q_rst.size() - br != 1 || q_done.size() - bd != 1) begin
      failures++;
      $display("FAIL overrun_no_new_line restarts=%0d dones=%0d exp=1,1",
               q_rst.size() - br, q_done.size() - bd);
    end
    checks++;
    if (line_cnt !== lc + 16'd1) begin
      failures++;
      $display("FAIL overrun_line_cnt got=%h exp=%h", line_cnt, lc + 16'd1);
    end
  endtask

  task automatic test_abort();
    int t0;
    int t1;
    int br = q_rst.size();
    int bs = q_st.size();
    int bd = q_done.size();
    int bf = q_bfall.size();
    logic [15:0] lc = line_cnt;
    pulse_trig(t0);
    wait_until(t0 + 90);
    enable = 1'b0;
    wait_until(t0 + 400);
    checks++;
    if (q_rst.size() - br != 2 || q_rst[br+1] != t0 + 91) begin
      failures++;
      $display("FAIL abort_restart n=%0d at=+%0d exp n=2 at=+91",
               q_rst.size() - br, q_rst[br+1] - t0);
    end
    checks++;
    if (q_bfall.size() - bf != 1 || q_bfall[bf] != t0 + 92) begin
      failures++;
      $display("FAIL abort_busy_fall at=+%0d exp=+92", q_bfall[bf] - t0);
    end
    checks++;
    if (q_st.size() - bs != 3) begin
      failures++;
      $display("FAIL abort_starts got=%0d exp=3", q_st.size() - bs);
    end
    checks++;
    if (q_done.size() != bd || line_cnt !== lc) begin
      failures++;
      $display("FAIL abort_no_done dones=%0d cnt=%h exp 0,%h",
               q_done.size() - bd, line_cnt, lc);
    end
    enable = 1'b1;
    pulse_trig(t1);
    wait_until(t1 + 340);
    checks++;
    if (q_st.size() - bs != 3 + PIX || q_done.size() - bd != 1 ||
        q_done[bd] != t1 + 327) begin
      failures++;
      $display("FAIL abort_next_line starts=%0d dones=%0d exp %0d,1",
               q_st.size() - bs, q_done.size() - bd, 3 + PIX);
    end
    checks++;
    if (line_cnt !== lc + 16'd1) begin
      failures++;
      $display("FAIL abort_next_cnt got=%h exp=%h", line_cnt, lc + 16'd1);
    end
  endtask

  task automatic test_wrap();
    int t0;
    int bd = q_done.size();
    @(negedge clk);
    force dut.line_cnt = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.line_cnt;
    @(negedge clk);
    checks++;
    if (line_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_preload got=%h exp=ffff", line_cnt);
    end
    cfg_settle = 16'd1;
    pulse_trig(t0);
    wait_until(t0 + 330);
    checks++;
    if (q_done.size() - bd != 1 || q_done[bd] != t0 + 323) begin
      failures++;
      $display("FAIL wrap_line_done at=+%0d exp=+323", q_done[bd] - t0);
    end
    checks++;
    if (line_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_line_cnt got=%h exp=0000", line_cnt);
    end
    cfg_settle = 16'd5;
  endtask

  task automatic test_async_reset();
    int t0;
    int t1;
    int br;
    pulse_trig(t0);
    wait_until(t0 + 50);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL areset_busy_before got=%b exp=1", busy);
    end
    br = q_rst.size();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ad7621_restart, ad7621_start, sensor_st, busy,
         line_done, trig_overrun} !== 6'b0 || line_cnt !== 16'h0) begin
      failures++;
      $display("FAIL areset_outs got=%b cnt=%h exp=000000 cnt=0000",
               {ad7621_restart, ad7621_start, sensor_st, busy,
                line_done, trig_overrun}, line_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (q_rst.size() != br || busy !== 1'b0) begin
      failures++;
      $display("FAIL areset_quiet restarts=%0d busy=%b exp 0,0",
               q_rst.size() - br, busy);
    end
    pulse_trig(t1);
    wait_until(t1 + 3);
    checks++;
    if (q_rst.size() - br != 1 || q_rst[br] != t1 + 1) begin
      failures++;
      $display("FAIL areset_first_trig n=%0d at=+%0d exp n=1 at=+1",
               q_rst.size() - br, q_rst[br] - t1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_overrun();
    test_abort();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
